// File: rtl/div_buf_pkg.sv
// div_buf_pkg
//   Shared defaults and state type for the in-order divider result buffer.
//   DIV*_DEF / TAG_WIDTH_DEF : default datapath and tag widths
//   DRAIN_CYCLES_DEF         : default divider latency (DIVIDEND_WIDTH + 2)
//   buf_state_e              : DRAIN / RUN controller states
package div_buf_pkg;

    localparam int DIVIDEND_WIDTH_DEF = 12;
    localparam int DIVISOR_WIDTH_DEF  = 6;
    localparam int TAG_WIDTH_DEF      = 6;
    localparam int DRAIN_CYCLES_DEF   = DIVIDEND_WIDTH_DEF + 2;

    typedef enum logic {
        ST_DRAIN = 1'b0,
        ST_RUN   = 1'b1
    } buf_state_e;

endpackage

// File: rtl/div_buf_store.sv
// div_buf_store
//   Tag-indexed result storage plus the issued/filled bookkeeping bits.
//   Optional feature macro: DIV_RESULT_BUFFER_DIVZERO_FLAG_EN (per-entry
//   zero-divisor bit captured at issue).
//   Ports:
//     clock, reset_n          clock, async active-low reset (bits only)
//     issue_en_i/issue_idx_i  mark an entry as issued
//     issue_zero_i            zero-divisor bit for the issued entry (macro)
//     wr_en_i/wr_idx_i        write divider result and mark filled
//     wr_quot_i/wr_rem_i      divider result data
//     wr_open_o               entry at wr_idx_i is issued and not yet filled
//     pop_en_i/pop_idx_i      release the entry at the read pointer
//     rd_filled_o             entry at pop_idx_i holds a result
//     rd_quot_o/rd_rem_o      data of the entry at pop_idx_i
//     rd_zero_o               zero-divisor bit at pop_idx_i (macro)
module div_buf_store
    import div_buf_pkg::*;
#(
    parameter int DATA_W = DIVIDEND_WIDTH_DEF,
    parameter int TAG_W  = TAG_WIDTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_en_i,
    input  logic [TAG_W-1:0]  issue_idx_i,
`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
    input  logic              issue_zero_i,
    output logic              rd_zero_o,
`endif
    input  logic              wr_en_i,
    input  logic [TAG_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_quot_i,
    input  logic [DATA_W-1:0] wr_rem_i,
    output logic              wr_open_o,
    input  logic              pop_en_i,
    input  logic [TAG_W-1:0]  pop_idx_i,
    output logic              rd_filled_o,
    output logic [DATA_W-1:0] rd_quot_o,
    output logic [DATA_W-1:0] rd_rem_o
);

    localparam int DEPTH = 2 ** TAG_W;

    logic [DEPTH-1:0]  issued_q, issued_d;
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [DATA_W-1:0] quot_q [DEPTH];
    logic [DATA_W-1:0] rem_q  [DEPTH];

    // Pop is applied last; a write and a pop never target the same entry
    // because popping requires the entry to be filled already.
    always_comb begin
        issued_d = issued_q;
        filled_d = filled_q;
        if (issue_en_i) begin
            issued_d[issue_idx_i] = 1'b1;
        end
        if (wr_en_i) begin
            filled_d[wr_idx_i] = 1'b1;
        end
        if (pop_en_i) begin
            issued_d[pop_idx_i] = 1'b0;
            filled_d[pop_idx_i] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            filled_q <= '0;
        end else begin
            issued_q <= issued_d;
            filled_q <= filled_d;
        end
    end

    // Data storage is deliberately left unreset; validity lives in filled_q.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            quot_q[wr_idx_i] <= wr_quot_i;
            rem_q[wr_idx_i]  <= wr_rem_i;
        end
    end

`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
    logic [DEPTH-1:0] zero_q;

    always_ff @(posedge clock) begin
        if (issue_en_i) begin
            zero_q[issue_idx_i] <= issue_zero_i;
        end
    end

    assign rd_zero_o = zero_q[pop_idx_i];
`endif

    assign wr_open_o   = issued_q[wr_idx_i] && !filled_q[wr_idx_i];
    assign rd_filled_o = filled_q[pop_idx_i];
    assign rd_quot_o   = quot_q[pop_idx_i];
    assign rd_rem_o    = rem_q[pop_idx_i];

endmodule

// File: rtl/div_result_buffer.sv
// div_result_buffer
//   Sits in front of a tagged, fixed-latency divider: issues requests with a
//   tag taken from a write pointer, collects out-of-band results by tag and
//   returns them strictly in issue order.
//   Optional feature macro: DIV_RESULT_BUFFER_DIVZERO_FLAG_EN adds
//   out_div_zero, flagging results whose request had a zero divisor.
//   Ports:
//     clock, reset_n                 clock, async active-low reset
//     in_valid/in_ready              request handshake
//     in_dividend/in_divisor         request operands
//     div_valid/div_tag/div_*        issue side of the divider
//     div_out_valid/div_out_tag      divider result strobe and tag
//     div_quotient/div_remainder     divider result data
//     out_valid/out_ready            in-order result handshake
//     out_quotient/out_remainder     result data at the read pointer
//     out_div_zero                   zero-divisor flag (macro only)
//     occupancy                      issued but not yet popped
//     err_stray                      sticky: result for unexpected tag
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_DRAIN | after reset; let stale divider results flush, ignore them
//   ST_RUN   | normal operation; left only by reset
module div_result_buffer
    import div_buf_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
    parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF,
    parameter int TAG_WIDTH      = TAG_WIDTH_DEF,
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
    output logic                      div_valid,
    output logic [TAG_WIDTH-1:0]      div_tag,
    output logic [DIVIDEND_WIDTH-1:0] div_dividend,
    output logic [DIVISOR_WIDTH-1:0]  div_divisor,
    input  logic                      div_out_valid,
    input  logic [TAG_WIDTH-1:0]      div_out_tag,
    input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
    input  logic [DIVIDEND_WIDTH-1:0] div_remainder,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] out_quotient,
    output logic [DIVIDEND_WIDTH-1:0] out_remainder,
    output logic [TAG_WIDTH:0]        occupancy,
`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
    output logic                      out_div_zero,
`endif
    output logic                      err_stray
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [TAG_WIDTH:0] OCC_FULL = {1'b1, {TAG_WIDTH{1'b0}}};

    buf_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [TAG_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [TAG_WIDTH:0]   occ_q, occ_d;
    logic                 err_q, err_d;

    logic issue;
    logic pop;
    logic res_valid;
    logic wr_open;
    logic wr_en;
    logic rd_filled;

    // Issue is a straight combinational pass-through to the divider.
    assign in_ready     = (state_q == ST_RUN) && (occ_q < OCC_FULL);
    assign issue        = in_valid && in_ready;
    assign div_valid    = issue;
    assign div_tag      = wr_ptr_q;
    assign div_dividend = in_dividend;
    assign div_divisor  = in_divisor;

    assign out_valid = rd_filled;
    assign pop       = rd_filled && out_ready;

    // Results seen while draining belong to work discarded by reset.
    assign res_valid = div_out_valid && (state_q == ST_RUN);
    assign wr_en     = res_valid && wr_open;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;

        case (state_q)
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
        endcase

        if (issue) begin
            wr_ptr_d = wr_ptr_q + TAG_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + TAG_WIDTH'(1);
        end

        case ({issue, pop})
            2'b10:   occ_d = occ_q + (TAG_WIDTH+1)'(1);
            2'b01:   occ_d = occ_q - (TAG_WIDTH+1)'(1);
            default: occ_d = occ_q;
        endcase

        if (res_valid && !wr_open) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_DRAIN;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    assign occupancy = occ_q;
    assign err_stray = err_q;

    div_buf_store #(
        .DATA_W (DIVIDEND_WIDTH),
        .TAG_W  (TAG_WIDTH)
    ) u_store (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_en_i   (issue),
        .issue_idx_i  (wr_ptr_q),
`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
        .issue_zero_i (in_divisor == '0),
        .rd_zero_o    (out_div_zero),
`endif
        .wr_en_i      (wr_en),
        .wr_idx_i     (div_out_tag),
        .wr_quot_i    (div_quotient),
        .wr_rem_i     (div_remainder),
        .wr_open_o    (wr_open),
        .pop_en_i     (pop),
        .pop_idx_i    (rd_ptr_q),
        .rd_filled_o  (rd_filled),
        .rd_quot_o    (out_quotient),
        .rd_rem_o     (out_remainder)
    );

endmodule

// File: tb/tb_div_result_buffer.sv
// tb_div_result_buffer
//   Directed bench for div_result_buffer with a behavioural 14-cycle
//   rounding divider in front of the result port. Honours
//   DIV_RESULT_BUFFER_DIVZERO_FLAG_EN for the zero-divisor flag.
module tb_div_result_buffer;

    localparam int LAT = 14;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_dividend;
    logic [5:0]  in_divisor;
    logic        div_valid;
    logic [5:0]  div_tag;
    logic [11:0] div_dividend;
    logic [5:0]  div_divisor;
    logic        div_out_valid;
    logic [5:0]  div_out_tag;
    logic [11:0] div_quotient;
    logic [11:0] div_remainder;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_quotient;
    logic [11:0] out_remainder;
    logic [6:0]  occupancy;
    logic        err_stray;
`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
    logic        out_div_zero;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    int iss;
    int seen_ov = 0;
    int seen_err = 0;
    logic watch = 1'b0;

    // Stray-result injection, overrides the divider model for one cycle.
    logic        inj_v;
    logic [5:0]  inj_tag;
    logic [11:0] inj_q;

    div_result_buffer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_valid     (div_valid),
        .div_tag       (div_tag),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_out_valid (div_out_valid),
        .div_out_tag   (div_out_tag),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .occupancy     (occupancy),
`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
        .out_div_zero  (out_div_zero),
`endif
        .err_stray     (err_stray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round-to-nearest signed divide, as the real divider does.
    function automatic logic [23:0] model_div(input logic signed [11:0] a, input logic [5:0] d);
        int ai, di, t, r, ar;
        ai = a;
        di = int'(d);
        if (di == 0) return {12'hFFF, a};
        t  = ai / di;
        r  = ai - t * di;
        ar = (r < 0) ? -r : r;
        if (2 * ar >= di) t = t + ((ai < 0) ? -1 : 1);
        r = ai - t * di;
        return {t[11:0], r[11:0]};
    endfunction

    // Divider pipeline; not reset, so pre-reset work still emerges later.
    logic        pv  [LAT];
    logic [5:0]  pt  [LAT];
    logic [23:0] pqr [LAT];

    always_ff @(posedge clock) begin
        pv[0]  <= div_valid;
        pt[0]  <= div_tag;
        pqr[0] <= model_div(div_dividend, div_divisor);
        for (int i = 1; i < LAT; i++) begin
            pv[i]  <= pv[i-1];
            pt[i]  <= pt[i-1];
            pqr[i] <= pqr[i-1];
        end
    end

    assign div_out_valid = inj_v | pv[LAT-1];
    assign div_out_tag   = inj_v ? inj_tag : pt[LAT-1];
    assign div_quotient  = inj_v ? inj_q : pqr[LAT-1][23:12];
    assign div_remainder = inj_v ? 12'h000 : pqr[LAT-1][11:0];

    always @(negedge clock) begin
        if (watch) begin
            if (out_valid) seen_ov++;
            if (err_stray) seen_err++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = 6'd1;
        out_ready   = 1'b1;
        inj_v       = 1'b0;
        inj_tag     = '0;
        inj_q       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_err_stray", err_stray, 0);
        check("rst_div_valid", div_valid, 0);

        // Drain window, then 100/7 and -100/7 back to back.
        reset_n     = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 12'd100;
        in_divisor  = 6'd7;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("drain_cycles", n, 14);
        check("first_tag", div_tag, 0);
        check("first_div_valid", div_valid, 1);
        @(posedge clock); #1;
        check("second_tag", div_tag, 1);
        in_dividend = 12'hF9C;
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("latency_edges", n, 14);
        check("q_pos", out_quotient, 12'h00E);
        check("r_pos", out_remainder, 12'h002);
        check("occ_two", occupancy, 2);
        @(posedge clock); #1;
        check("ov_second", out_valid, 1);
        check("q_neg", out_quotient, 12'hFF2);
        check("r_neg", out_remainder, 12'hFFE);
        @(posedge clock); #1;
        check("ov_empty", out_valid, 0);
        check("occ_empty", occupancy, 0);

        // Fill all 64 entries (pointer wraps from 2) with out_ready low.
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_dividend = 12'd21;
        in_divisor  = 6'd5;
        iss = 0;
        n = 0;
        while (iss < 64 && n < 200) begin
            if (in_ready) iss++;
            @(posedge clock); #1; n++;
        end
        check("full_issued", iss, 64);
        check("full_in_ready", in_ready, 0);
        check("full_div_valid", div_valid, 0);
        check("full_occupancy", occupancy, 64);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("full_q", out_quotient, 12'd4);
        check("full_r", out_remainder, 12'd1);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("pop_in_ready", in_ready, 1);
        check("pop_occupancy", occupancy, 63);
        check("pop_next_valid", out_valid, 1);
        repeat (20) @(posedge clock);
        #1;

        // Stray result for a tag that was never issued.
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst2_occupancy", occupancy, 0);
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clock); #1; n++;
        end
        inj_v   = 1'b1;
        inj_tag = 6'd5;
        inj_q   = 12'h123;
        @(posedge clock); #1;
        inj_v = 1'b0;
        check("stray_err", err_stray, 1);
        check("stray_ov", out_valid, 0);
        check("stray_occ", occupancy, 0);
        repeat (5) @(posedge clock);
        #1;
        check("stray_sticky", err_stray, 1);

        // Reset with ten requests in flight.
        in_valid    = 1'b1;
        in_dividend = 12'd50;
        in_divisor  = 6'd3;
        iss = 0;
        n = 0;
        while (iss < 10 && n < 40) begin
            if (in_ready) iss++;
            @(posedge clock); #1; n++;
        end
        in_valid = 1'b0;
        check("flight_occ", occupancy, 10);
        reset_n = 1'b0;
        #1;
        watch = 1'b1;
        check("flight_rst_err", err_stray, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        watch = 1'b0;
        check("flight_no_output", seen_ov, 0);
        check("flight_no_err", seen_err, 0);
        check("flight_in_ready", in_ready, 1);
        check("flight_next_tag", div_tag, 0);
        check("flight_occ_zero", occupancy, 0);

`ifdef DIV_RESULT_BUFFER_DIVZERO_FLAG_EN
        // Zero divisor followed by a normal request.
        in_valid    = 1'b1;
        in_dividend = 12'd10;
        in_divisor  = 6'd0;
        @(posedge clock); #1;
        in_divisor = 6'd3;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("dz_flag_set", out_div_zero, 1);
        @(posedge clock); #1;
        check("dz_next_valid", out_valid, 1);
        check("dz_flag_clear", out_div_zero, 0);
        check("dz_next_q", out_quotient, 12'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 Parameters SHALL be:
- DIVIDEND_WIDTH, default 12, dividend/quotient/remainder width.
- DIVISOR_WIDTH, default 6, divisor width.
- TAG_WIDTH, default 6, tag width; buffer depth is 2**TAG_WIDTH.
- DRAIN_CYCLES, default 14, divider latency in cycles (DIVIDEND_WIDTH+2).

REQ-002 Ports SHALL be, one clock; reset is asynchronous and active-low:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request offered.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_dividend  in  DIVIDEND_WIDTH  signed dividend.
- in_divisor  in  DIVISOR_WIDTH  unsigned divisor.
- div_valid  out  1  issue to divider input_valid.
- div_tag  out  TAG_WIDTH  issue to divider input_tag.
- div_dividend  out  DIVIDEND_WIDTH  issue to divider dividend.
- div_divisor  out  DIVISOR_WIDTH  issue to divider divisor.
- div_out_valid  in  1  divider output_valid.
- div_out_tag  in  TAG_WIDTH  divider output_tag.
- div_quotient  in  DIVIDEND_WIDTH  divider quotient.
- div_remainder  in  DIVIDEND_WIDTH  divider remainder.
- out_valid  out  1  in-order result available.
- out_ready  in  1  consumer accepts.
- out_quotient  out  DIVIDEND_WIDTH  result quotient.
- out_remainder  out  DIVIDEND_WIDTH  result remainder.
- occupancy  out  TAG_WIDTH+1  issued-but-not-popped count.
- err_stray  out  1  sticky: result for unissued or already-filled tag.

Function
REQ-003 The block SHALL be combinational pass-through on issue: div_valid = in_valid && in_ready; div_tag = wr_ptr; div_dividend/div_divisor = in_dividend/in_divisor.
REQ-004 State machine SHALL have states DRAIN and RUN: reset enters DRAIN; DRAIN counts DRAIN_CYCLES cycles then goes to RUN; RUN has no exit except reset.
REQ-005 in_ready SHALL be 1 only in RUN with occupancy < 2**TAG_WIDTH.
REQ-006 On issue: set issued[wr_ptr]; wr_ptr increments modulo 2**TAG_WIDTH.
REQ-007 On div_out_valid with issued[tag]=1 and filled[tag]=0: store quotient/remainder at tag and set filled[tag] at the clock edge.
REQ-008 On div_out_valid with issued[tag]=0 or filled[tag]=1: drop the data and set err_stray.
REQ-009 out_valid SHALL equal filled[rd_ptr]; out_quotient/out_remainder SHALL read the entry at rd_ptr combinationally.
REQ-010 On out_valid && out_ready: clear issued and filled at rd_ptr; rd_ptr increments modulo depth.
REQ-011 occupancy SHALL increment on issue and decrement on pop; simultaneous issue and pop SHALL leave it unchanged.
REQ-012 Write to tag T and pop of T in the same cycle is impossible (pop requires filled); issue at T equal to rd_ptr being popped SHALL only occur when occupancy = 2**TAG_WIDTH, which is excluded by REQ-005.
REQ-013 Latency from accepted request to out_valid SHALL be DRAIN_CYCLES+1 cycles with out_ready held high; the pipeline sustains one result per cycle.
REQ-014 Results SHALL leave strictly in issue order; out_valid stays high with stable data until accepted.

Reset
REQ-015 Reset SHALL force: DRAIN, drain counter 0, wr_ptr=rd_ptr=0, occupancy 0, all issued/filled 0, err_stray 0, in_ready 0, out_valid 0. Data storage is not reset.
REQ-016 Reset mid-operation SHALL discard all in-flight work; divider results arriving during DRAIN SHALL be dropped and SHALL NOT set err_stray.

Configuration
REQ-017 Macro DIV_RESULT_BUFFER_DIVZERO_FLAG_EN:
- defined: a per-entry zero-divisor bit is captured at issue (in_divisor==0), and output out_div_zero (1 bit) accompanies out_valid with that bit.
- undefined: no bit storage and no out_div_zero port.

Structure
REQ-018 Package div_buf_pkg SHALL hold default widths, DRAIN_CYCLES default and the DRAIN/RUN state enum.
REQ-019 Sub-module div_buf_store SHALL contain the data array and issued/filled bit vectors with write, pop and issue ports.

Verification
REQ-020 Reset, then hold in_valid: in_ready first high 14 cycles after reset release; first issue carries tag 0.
REQ-021 Issue 100/7 and -100/7 through the real divider (rounding on): out quotients 14 and -14 in order at accepted+15 cycles.
REQ-022 out_ready low while issuing 64 requests: in_ready drops after the 64th issue; occupancy is 64; one pop restores in_ready next cycle.
REQ-023 Inject div_out_valid with tag 5 when never issued: data dropped, err_stray stays 1 until reset.
REQ-024 Assert reset with 10 in flight: no output appears, no err_stray; next issue uses tag 0.
REQ-025 With DIV_RESULT_BUFFER_DIVZERO_FLAG_EN, issue divisor 0: out_div_zero=1 for that result only.
